// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU; result XLEN/STEPS_PER_CYCLE+1 cycles after start.
// No backpressure: start is taken only when idle, and is dropped rather than queued while busy.
module mul_unit #(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      mul_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CYCLES = XLEN / STEPS_PER_CYCLE;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     result_d;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [2*XLEN-1:0]   acc_t, mc_t, prod;
  logic [XLEN-1:0]     mp_t;

  always_comb begin
    a_neg = ((mul_op == OP_MULH) || (mul_op == OP_MULHSU)) && operand_a[XLEN-1];
    b_neg = (mul_op == OP_MULH) && operand_b[XLEN-1];
    // Negating the most negative value wraps back to itself, which is the correct unsigned magnitude.
    a_mag = a_neg ? -operand_a : operand_a;
    b_mag = b_neg ? -operand_b : operand_b;

    acc_t = acc_q;
    mc_t  = mcand_q;
    mp_t  = mplier_q;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (mp_t[0]) acc_t = acc_t + mc_t;
      mc_t = mc_t << 1;
      mp_t = mp_t >> 1;
    end
    prod = neg_q ? -acc_t : acc_t;

    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d  = S_CALC;
          op_d     = mul_op;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, a_mag};
          mplier_d = b_mag;
          cnt_d    = CNT_INIT;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_t;
          mcand_d  = mc_t;
          mplier_d = mp_t;
          cnt_d    = cnt_q - CNT_ONE;
          // Final step's sum feeds the result directly so DONE holds the finished slice.
          if (cnt_q == '0) begin
            state_d  = S_DONE;
            result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result   <= result_d;
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
    end
  end

endmodule
